// File: rtl/mseq_pkg.sv
// Shared definitions for the microprogrammed control unit: control-state
// width, reserved state addresses and next-state mode encodings. Imported
// by the microsequencer, control store and instruction state encoder.
package mseq_pkg;

   localparam int STATE_W = 7;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t RESET_STATE = state_t'(0);
   localparam state_t FETCH_STATE = state_t'(1);
   localparam state_t ERR_STATE   = state_t'(127);

   // Next-state mode field of the control word.
   typedef enum logic [2:0] {
      NM_DISPATCH = 3'd0,
      NM_FETCH    = 3'd1,
      NM_INCR     = 3'd2,
      NM_JUMP     = 3'd3,
      NM_CJUMP    = 3'd4,
      NM_WAIT     = 3'd5,
      NM_RSVD6    = 3'd6,
      NM_RSVD7    = 3'd7
   } nmode_t;

endpackage

// File: rtl/mseq_next_sel.sv
// Combinational next-state selector and incrementer.
// Ports:
//   i_state        current control state
//   i_state_sel    dispatch state from the encoder
//   i_n_mode       next-state mode from the control word
//   i_cr_addr      jump target from the control word
//   i_cond_eff     effective condition (Cond ^ Inv)
//   i_wait_expire  wait timeout fires this cycle (forces ERR_STATE in WAIT)
//   o_next_state   selected next state
//   o_dispatch     this selection is a dispatch load
//   o_illegal      reserved mode decoded
module mseq_next_sel
   import mseq_pkg::*;
(
   input  logic [STATE_W-1:0] i_state,
   input  logic [STATE_W-1:0] i_state_sel,
   input  logic [2:0]         i_n_mode,
   input  logic [STATE_W-1:0] i_cr_addr,
   input  logic               i_cond_eff,
   input  logic               i_wait_expire,
   output logic [STATE_W-1:0] o_next_state,
   output logic               o_dispatch,
   output logic               o_illegal
);

   logic [STATE_W-1:0] w_incr;

   // Wraps modulo 2^STATE_W with no flag.
   assign w_incr = i_state + 1'b1;

   always_comb begin
      o_next_state = i_state;
      o_dispatch   = 1'b0;
      o_illegal    = 1'b0;
      case (i_n_mode)
         NM_DISPATCH: begin
            o_next_state = i_state_sel;
            o_dispatch   = 1'b1;
         end
         NM_FETCH: o_next_state = FETCH_STATE;
         NM_INCR:  o_next_state = w_incr;
         NM_JUMP:  o_next_state = i_cr_addr;
         NM_CJUMP: o_next_state = i_cond_eff ? i_cr_addr : w_incr;
         NM_WAIT: begin
            if (i_wait_expire) o_next_state = ERR_STATE;
            else               o_next_state = i_cond_eff ? w_incr : i_state;
         end
         default: begin
            o_next_state = ERR_STATE;
            o_illegal    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// Control-state register of the microprogrammed control unit. Registers
// the next control state every clock; State addresses the microstore.
// Optional wait timeout enabled by defining MSEQ_TIMEOUT_EN.
// Ports:
//   Clk, Reset_n   clock, asynchronous active-low reset
//   State_Sel      dispatch state from the encoder
//   N_Mode         next-state mode from the control word
//   CR_Addr        jump target from the control word
//   Cond, Inv      condition and its inversion (C = Cond ^ Inv)
//   Stall          hold everything this cycle
//   State          current control state
//   Dispatched     pulse: State was just loaded from State_Sel
//   Illegal        pulse: reserved N_Mode was decoded
//   Timeout        pulse: wait timeout fired (0 without MSEQ_TIMEOUT_EN)
module microsequencer
   import mseq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [STATE_W-1:0] State_Sel,
   input  logic [2:0]         N_Mode,
   input  logic [STATE_W-1:0] CR_Addr,
   input  logic               Cond,
   input  logic               Inv,
   input  logic               Stall,
   output logic [STATE_W-1:0] State,
   output logic               Dispatched,
   output logic               Illegal,
   output logic               Timeout
);

   logic [STATE_W-1:0] r_state;
   logic               r_dispatched;
   logic               r_illegal;
   logic [STATE_W-1:0] w_next_state;
   logic               w_dispatch;
   logic               w_illegal;
   logic               w_cond;
   logic               w_wait_expire;

   assign w_cond = Cond ^ Inv;

   mseq_next_sel u_next_sel (
      .i_state       (r_state),
      .i_state_sel   (State_Sel),
      .i_n_mode      (N_Mode),
      .i_cr_addr     (CR_Addr),
      .i_cond_eff    (w_cond),
      .i_wait_expire (w_wait_expire),
      .o_next_state  (w_next_state),
      .o_dispatch    (w_dispatch),
      .o_illegal     (w_illegal)
   );

   // Pulse flops hold across a stall; the outputs are masked while stalled
   // so a held pulse shows exactly once, after the stall releases.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= RESET_STATE;
         r_dispatched <= 1'b0;
         r_illegal    <= 1'b0;
      end else if (!Stall) begin
         r_state      <= w_next_state;
         r_dispatched <= w_dispatch;
         r_illegal    <= w_illegal;
      end
   end

   assign State      = r_state;
   assign Dispatched = r_dispatched & ~Stall;
   assign Illegal    = r_illegal & ~Stall;

`ifdef MSEQ_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout;
   logic             w_wait_fail;

   assign w_wait_fail   = (N_Mode == NM_WAIT) && !w_cond;
   assign w_wait_expire = w_wait_fail && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else if (!Stall) begin
         r_wait_cnt <= (w_wait_fail && !w_wait_expire) ? r_wait_cnt + 1'b1 : '0;
         r_timeout  <= w_wait_expire;
      end
   end

   assign Timeout = r_timeout & ~Stall;
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign w_wait_expire        = 1'b0;
   assign Timeout              = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
   import mseq_pkg::*;

   logic               Clk = 1'b0;
   logic               Reset_n;
   logic [STATE_W-1:0] State_Sel;
   logic [2:0]         N_Mode;
   logic [STATE_W-1:0] CR_Addr;
   logic               Cond;
   logic               Inv;
   logic               Stall;
   logic [STATE_W-1:0] State;
   logic               Dispatched;
   logic               Illegal;
   logic               Timeout;

   int n_vec = 0;
   int n_err = 0;

   microsequencer #(.TIMEOUT_CYCLES(4)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .State_Sel  (State_Sel),
      .N_Mode     (N_Mode),
      .CR_Addr    (CR_Addr),
      .Cond       (Cond),
      .Inv        (Inv),
      .Stall      (Stall),
      .State      (State),
      .Dispatched (Dispatched),
      .Illegal    (Illegal),
      .Timeout    (Timeout)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int st, input int d, input int il, input int to);
      chk({tag, ".state"}, int'(State), st);
      chk({tag, ".disp"},  int'(Dispatched), d);
      chk({tag, ".ill"},   int'(Illegal), il);
      chk({tag, ".tmo"},   int'(Timeout), to);
   endtask

   // Drive one cycle of inputs (a feeds both State_Sel and CR_Addr), then
   // sample 1 ns after the rising edge.
   task automatic apply(input logic [2:0] m, input int a, input logic c,
                        input logic v, input logic s);
      N_Mode    = m;
      State_Sel = STATE_W'(a);
      CR_Addr   = STATE_W'(a);
      Cond      = c;
      Inv       = v;
      Stall     = s;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n = 1'b0;
      N_Mode = NM_FETCH; State_Sel = '0; CR_Addr = '0;
      Cond = 1'b0; Inv = 1'b0; Stall = 1'b0;
      #12;
      chk_all("reset", 0, 0, 0, 0);
      Reset_n = 1'b1;

      apply(NM_FETCH, 0, 0, 0, 0);     chk_all("fetch", 1, 0, 0, 0);
      apply(NM_DISPATCH, 18, 0, 0, 0); chk_all("dispatch", 18, 1, 0, 0);
      apply(NM_INCR, 0, 0, 0, 0);      chk_all("incr_after_disp", 19, 0, 0, 0);

      apply(NM_JUMP, 20, 0, 0, 0);     chk("jump20", int'(State), 20);
      apply(NM_CJUMP, 40, 1, 0, 0);    chk("cj_c1i0", int'(State), 40);
      apply(NM_JUMP, 20, 0, 0, 0);     chk("jump20b", int'(State), 20);
      apply(NM_CJUMP, 40, 1, 1, 0);    chk("cj_c1i1", int'(State), 21);
      apply(NM_CJUMP, 40, 0, 0, 0);    chk("cj_c0i0", int'(State), 22);
      apply(NM_CJUMP, 40, 0, 1, 0);    chk("cj_c0i1", int'(State), 40);

      // WAIT released on the limit cycle: C=1 wins over the timeout.
      apply(NM_JUMP, 13, 0, 0, 0);     chk("jump13", int'(State), 13);
      for (int i = 0; i < 3; i++) begin
         apply(NM_WAIT, 0, 0, 0, 0);   chk_all("wait_hold", 13, 0, 0, 0);
      end
      apply(NM_WAIT, 0, 1, 0, 0);      chk_all("wait_go", 14, 0, 0, 0);

      apply(NM_JUMP, 127, 0, 0, 0);    chk("jump127", int'(State), 127);
      apply(NM_INCR, 0, 0, 0, 0);      chk_all("wrap", 0, 0, 0, 0);
      apply(NM_RSVD6, 0, 0, 0, 0);     chk_all("rsvd6", 127, 0, 1, 0);
      apply(NM_RSVD7, 5, 0, 0, 0);     chk_all("rsvd7", 127, 0, 1, 0);
      apply(NM_FETCH, 0, 0, 0, 0);     chk_all("after_ill", 1, 0, 0, 0);

      apply(NM_JUMP, 55, 0, 0, 1);     chk_all("stall_jump", 1, 0, 0, 0);
      apply(NM_JUMP, 55, 0, 0, 0);     chk_all("unstall_jump", 55, 0, 0, 0);
      apply(NM_DISPATCH, 30, 0, 0, 1); chk_all("stall_disp", 55, 0, 0, 0);
      apply(NM_DISPATCH, 30, 0, 0, 0); chk_all("unstall_disp", 30, 1, 0, 0);
      apply(NM_INCR, 0, 0, 0, 0);      chk_all("disp_once", 31, 0, 0, 0);

      apply(NM_JUMP, 13, 0, 0, 0);     chk("jump13b", int'(State), 13);
`ifdef MSEQ_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         apply(NM_WAIT, 0, 0, 0, 0);   chk_all("tmo_hold", 13, 0, 0, 0);
      end
      apply(NM_WAIT, 0, 0, 0, 0);      chk_all("tmo_fire", 127, 0, 0, 1);
      apply(NM_FETCH, 0, 0, 0, 0);     chk_all("tmo_once", 1, 0, 0, 0);
`else
      for (int i = 0; i < 6; i++) begin
         apply(NM_WAIT, 0, 0, 0, 0);   chk_all("wait_forever", 13, 0, 0, 0);
      end
      apply(NM_FETCH, 0, 0, 0, 0);     chk("wait_exit", int'(State), 1);
`endif

      // Asynchronous reset in the middle of a wait.
      apply(NM_JUMP, 13, 0, 0, 0);     chk("jump13c", int'(State), 13);
      apply(NM_WAIT, 0, 0, 0, 0);      chk("midwait1", int'(State), 13);
      apply(NM_WAIT, 0, 0, 0, 0);      chk("midwait2", int'(State), 13);
      #2 Reset_n = 1'b0;
      #1 chk_all("async_rst", 0, 0, 0, 0);
      #10 Reset_n = 1'b1;
      chk("rst_held", int'(State), 0);
`ifdef MSEQ_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         apply(NM_WAIT, 0, 0, 0, 0);   chk_all("cnt_cleared", 0, 0, 0, 0);
      end
      apply(NM_WAIT, 0, 0, 0, 0);      chk_all("tmo_after_rst", 127, 0, 0, 1);
`else
      for (int i = 0; i < 4; i++) begin
         apply(NM_WAIT, 0, 0, 0, 0);   chk_all("wait_after_rst", 0, 0, 0, 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Control-state register and next-state selector of the microprogrammed control unit.
- Sits directly downstream of the instruction state encoder. It takes the encoder's 7-bit dispatch state and the next-state fields of the current control word, and registers the next control state every clock.
- Its State output addresses the control store (microstore).

Parameters:
- STATE_W, 7, width of the control-state address.
- RESET_STATE, 0, state loaded on reset.
- FETCH_STATE, 1, instruction-fetch state (also the encoder's default).
- ERR_STATE, 127, state entered on illegal next-mode or wait timeout.
- TIMEOUT_CYCLES, 16, wait-timeout limit; used only with MSEQ_TIMEOUT_EN.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- State_Sel  in  STATE_W  dispatch state from the encoder.
- N_Mode  in  3  next-state mode from the current control word.
- CR_Addr  in  STATE_W  jump target from the current control word.
- Cond  in  1  condition input (MOC, ALU flag, etc., muxed upstream).
- Inv  in  1  condition inversion from the control word; effective condition C = Cond ^ Inv.
- Stall  in  1  hold the current state this cycle.
- State  out  STATE_W  current control state.
- Dispatched  out  1  one-cycle pulse: State was just loaded from State_Sel.
- Illegal  out  1  one-cycle pulse: reserved N_Mode was decoded.
- Timeout  out  1  one-cycle pulse: wait timeout fired.

Behaviour:
- Reset (asynchronous, any time including mid-wait):
  - State=RESET_STATE.
  - Dispatched=Illegal=Timeout=0.
  - Wait counter=0.
- State updates on the rising Clk edge only; latency is 1 cycle from inputs to State.
- Next-state selection by N_Mode:
  - 0 DISPATCH: State_Sel.
  - 1 FETCH: FETCH_STATE.
  - 2 INCR: State+1.
  - 3 JUMP: CR_Addr.
  - 4 CJUMP: C ? CR_Addr : State+1.
  - 5 WAIT: C ? State+1 : State (hold).
  - 6, 7 reserved: ERR_STATE; Illegal=1 next cycle.
- Increment is modulo 2^STATE_W: 127+1 wraps to 0 with no flag.
- Stall=1:
  - State, wait counter and all pulse sources hold.
  - Pulse outputs are forced to 0 for that cycle.
  - Stall has priority over every N_Mode.
- Dispatched=1 for exactly one cycle after a non-stalled DISPATCH load; Illegal likewise for a reserved mode.
- Each output pulse is registered and is never high for two consecutive cycles from a single event.
- RESET_STATE is an ordinary state: the microcode in it must select FETCH.

Optional Feature:
- Macro: MSEQ_TIMEOUT_EN.
- Defined:
  - Wait counter counts consecutive non-stalled WAIT cycles with C=0.
  - When the counter reaches TIMEOUT_CYCLES-1 and C is still 0, the next state is ERR_STATE, Timeout pulses for 1 cycle, and the counter clears.
  - The counter also clears on any non-WAIT mode or on C=1.
  - C=1 on the limit cycle wins: normal increment, no Timeout.
  - Stall freezes the counter.
- Undefined: no counter; WAIT holds indefinitely; Timeout tied to 0.

Decomposition:
- Shared package (mseq_pkg):
  - STATE_W.
  - N_Mode encodings as named constants (NM_DISPATCH … NM_WAIT).
  - RESET_STATE, FETCH_STATE, ERR_STATE.
  - This package is also imported by the control store and encoder.
- One natural sub-module, mseq_next_sel: purely combinational next-address mux plus incrementer.
- The top level holds the state register, pulse flops and the optional timeout counter.

Test Plan:
- Reset, then N_Mode=1 → State: 0 → 1. Then N_Mode=0 with State_Sel=18 → State=18 and Dispatched=1 for one cycle.
- State=20, N_Mode=4, CR_Addr=40:
  - Cond=1, Inv=0 → 40.
  - Cond=1, Inv=1 → 21.
- State=13, N_Mode=5, Cond=0 for 3 cycles then 1 → State holds 13 for 3 cycles, then 14.
- State=127, N_Mode=2 → 0, no flag. N_Mode=6 → State=127 and Illegal=1 for one cycle.
- Stall=1 during N_Mode=3 → State unchanged and no pulses; release → jumps to CR_Addr next edge.
- With MSEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4: WAIT with Cond=0 → State=127 after the 4th wait cycle and Timeout=1 once.
- Reset_n low mid-wait → State=0 immediately (asynchronous) and the counter is cleared.
